// File: rtl/demux_edge_counter.sv
// Per-channel rising-edge counter for the 1-to-8 demux outputs, with registered read/clear port.
// Optional sticky overflow flags are enabled by defining DEMUX_CNT_OVF_EN.
module demux_edge_counter #(
    parameter int CNT_W = 8,
    parameter int N_CH  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  ch_in,
    input  logic             rd_en,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    input  logic             clr_en,
    input  logic [2:0]       clr_sel,
    output logic             act_any,
    output logic [2:0]       act_ch
`ifdef DEMUX_CNT_OVF_EN
    ,
    output logic [N_CH-1:0]  ovf
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0]  ch_q;
    logic [N_CH-1:0]  rise;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             act_any_q;
    logic [2:0]       act_ch_q;
    logic [2:0]       act_ch_d;

    assign rise = ch_in & ~ch_q;

    // A clear coinciding with an edge leaves a count of one so the edge is not lost.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clr_en && (clr_sel == 3'(k))) begin
                cnt_d[k] = rise[k] ? CNT_W'(1) : '0;
            end else if (rise[k] && (cnt_q[k] != CNT_MAX)) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        act_ch_d = 3'd0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_q[k]) act_ch_d = 3'(k);
        end
    end

`ifdef DEMUX_CNT_OVF_EN
    logic [N_CH-1:0] ovf_q;
    logic [N_CH-1:0] ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        for (int k = 0; k < N_CH; k++) begin
            if (clr_en && (clr_sel == 3'(k))) begin
                ovf_d[k] = 1'b0;
            end else if (rise[k] && (cnt_q[k] == CNT_MAX)) begin
                ovf_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= '0;
        else       ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

    // ch_q resets high so a channel already asserted at reset release is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_q       <= '1;
            cnt_q      <= '{default: '0};
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            act_any_q  <= 1'b0;
            act_ch_q   <= 3'd0;
        end else begin
            ch_q       <= ch_in;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_en;
            if (rd_en) rd_data_q <= cnt_q[rd_sel];
            act_any_q  <= |ch_q;
            act_ch_q   <= act_ch_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign act_any  = act_any_q;
    assign act_ch   = act_ch_q;

endmodule

// File: doc/demux_edge_counter.md
Name: demux_edge_counter

Overview:
- Downstream consumer of the 1-to-8 `demux_generate` stage.
- Samples the eight demux outputs o0..o7 on `clk` and detects rising edges per channel.
- Accumulates each channel's edge count in a saturating counter.
- Exposes a registered read port and a per-channel clear port, so firmware and benches can check that the demux steered pulses to the selected output only.

Parameters:
- CNT_W, 8, width of each per-channel edge counter; saturates at 2^CNT_W-1.
- N_CH, 8, number of channels; fixed to match the 3-bit demux select; only 8 is supported.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ch_in  input  8  demux outputs; ch_in[k] is wired to o<k>; asynchronous to clk's data phase but treated as sampled levels.
- rd_en  input  1  read request.
- rd_sel  input  3  channel index to read.
- rd_data  output  CNT_W  counter value of the requested channel.
- rd_valid  output  1  rd_data is valid this cycle.
- clr_en  input  1  clear request.
- clr_sel  input  3  channel index to clear.
- act_any  output  1  registered OR of sampled ch_in.
- act_ch  output  3  index of the highest-numbered sampled-high channel; 0 when none is high.

Behaviour:
- Sampling
  - ch_q <= ch_in every cycle.
  - edge[k] = ch_in[k] & ~ch_q[k].
  - Pulses shorter than one clk period may be missed; clk must run faster than 2x the input toggle rate.
- Reset (synchronous, reset=1 at a clk edge)
  - ch_q <= 8'hFF, so an input already high at reset release is not counted.
  - All counters <= 0.
  - rd_data <= 0, rd_valid <= 0, act_any <= 0, act_ch <= 0.
  - Reset overrides rd_en and clr_en in the same cycle.
  - Reset asserted mid-readout: rd_valid is 0 in the following cycle.
- Counting
  - If edge[k] and cnt[k] < max: cnt[k] <= cnt[k]+1.
  - At max, cnt[k] holds; no wrap-around.
  - All eight channels count independently in the same cycle. Several may edge together if the demux glitches on a select change; each is counted.
- Clear
  - clr_en=1 sets cnt[clr_sel] <= 0, unless edge[clr_sel] is also 1 that cycle, in which case cnt[clr_sel] <= 1. The edge is never lost.
  - Other channels are unaffected.
- Read
  - Latency is 1 cycle: rd_en=1 in cycle t gives rd_valid=1 and rd_data=cnt[rd_sel] in cycle t+1.
  - rd_data returns the value held before any cycle-t increment or clear; it is the pre-update snapshot.
  - rd_valid=0 when there was no request; rd_data then holds its last value.
  - Back-to-back reads are allowed every cycle.
- Read and clear of the same channel in the same cycle: the read returns the pre-clear value, and the counter is cleared.
- Activity outputs
  - Registered from ch_q; 1 cycle behind ch_q (2 cycles behind ch_in).
  - Priority encoder with highest index wins.
- No state machine beyond the registers above. The datapath is purely registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: DEMUX_CNT_OVF_EN.
- Defined:
  - Adds output port `ovf`, 8 bits.
  - ovf[k] is a sticky flag that sets when edge[k]=1 while cnt[k] is at max.
  - Cleared by reset, or by clr_en with clr_sel=k. Clear wins over a same-cycle set.
- Not defined:
  - No `ovf` port and no flag registers.
  - Saturation is silent.
  - All other behaviour is identical.

Test Plan:
- Reset release with ch_in=8'h01 held high -> cnt[0] stays 0. Then drop ch_in[0] and raise it once -> read ch0 returns 1 with rd_valid exactly one cycle after rd_en.
- Drive the demux with sel=3, i toggling 5 full periods -> reads of ch3=5 and all other channels=0. Also act_ch=3 and act_any=1 while ch_in[3] is high.
- CNT_W=4: 20 rising edges on ch6 -> cnt[6]=15. With DEMUX_CNT_OVF_EN, ovf[6]=1 and ovf is otherwise 0; without it, the port is absent and the build is clean.
- clr_en with clr_sel=2 in the same cycle as a ch2 rising edge -> cnt[2]=1. Clear with no edge -> cnt[2]=0.
- Same-cycle rd_en and clr_en on ch5 with cnt=7 -> rd_data=7, rd_valid=1. A subsequent read of ch5 returns 0.
- Reset asserted the cycle after rd_en -> rd_valid=0 next cycle, and all reads after reset return 0.
